// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single-port data_ram. It parks on master 0 (CPU) and uses
// bounded bursts so that neither master is starved.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                m0_ce,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_wait,
  input  logic                m1_ce,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_wait,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                owner
);

  localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

  typedef enum logic {StOwn0 = 1'b0, StOwn1 = 1'b1} owner_e;

  owner_e     owner_q, owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       owner_ce;
  logic       burst_last;

  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q     <= StOwn0;
      burst_cnt_q <= 8'd0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    owner_ce    = (owner_q == StOwn1) ? m1_ce : m0_ce;
    burst_last  = (burst_cnt_q == BurstLast);
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    unique case (owner_q)
      StOwn0: if (m1_ce && (!m0_ce || burst_last)) owner_d = StOwn1;
      StOwn1: if (!m1_ce || (m0_ce && burst_last)) owner_d = StOwn0;
    endcase
    // A new tenure always starts counting from zero; the count saturates at the last slot.
    if (owner_d != owner_q) begin
      burst_cnt_d = 8'd0;
    end else if (owner_ce && !burst_last) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end
  end

  // All outputs are forced low while reset is asserted so no RAM write can occur.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    m0_wait   = 1'b0;
    m1_wait   = 1'b0;
    owner     = 1'b0;
    if (reset) begin
      owner    = (owner_q == StOwn1);
      m0_rdata = ram_rdata;
      m1_rdata = ram_rdata;
      m0_wait  = m0_ce && (owner_q == StOwn1);
      m1_wait  = m1_ce && (owner_q == StOwn0);
      if (owner_q == StOwn1) begin
        ram_ce    = m1_ce;
        ram_we    = m1_ce && m1_we;
        ram_addr  = m1_addr;
        ram_sel   = m1_sel;
        ram_wdata = m1_wdata;
      end else begin
        ram_ce    = m0_ce;
        ram_we    = m0_ce && m0_we;
        ram_addr  = m0_addr;
        ram_sel   = m0_sel;
        ram_wdata = m0_wdata;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter: directed scenarios followed by random traffic,
// predicted by a tenure-counting reference model with its own memory image.
module tb_data_ram_arbiter;

  localparam int MaxBurst = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m0_ce = 1'b0, m0_we = 1'b0, m1_ce = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        m0_wait, m1_wait, ram_ce, ram_we, owner;
  logic [3:0]  ram_sel;

  always #5 clock = ~clock;

  data_ram_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .m0_ce    (m0_ce),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_sel   (m0_sel),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m0_wait  (m0_wait),
    .m1_ce    (m1_ce),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_sel   (m1_sel),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .m1_wait  (m1_wait),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_sel  (ram_sel),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .owner    (owner)
  );

  // Behavioural data_ram: combinational read, byte-lane write at the edge.
  logic [31:0] tb_mem [16] = '{default: '0};
  assign ram_rdata = tb_mem[ram_addr[5:2]];
  always @(posedge clock) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) tb_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        own, w0, w1, ce, we, chk0, chk1;
    logic [31:0] addr, wdata, rd;
    logic [3:0]  sel;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        m_own = 1'b0;
  int          m_served = 0;
  logic [31:0] m_mem [16] = '{default: '0};
  logic        last_w0 = 1'b0, last_w1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and push the model's prediction for it.
  task automatic drive(input logic r,
                       input logic c0, input logic w0, input logic [31:0] a0,
                       input logic [3:0] s0, input logic [31:0] d0,
                       input logic c1, input logic w1, input logic [31:0] a1,
                       input logic [3:0] s1, input logic [31:0] d1);
    exp_t        e;
    logic        oce, owe, other, sw;
    logic [31:0] oa, od;
    logic [3:0]  os;
    @(posedge clock);
    #1;
    reset = r;
    m0_ce = c0; m0_we = w0; m0_addr = a0; m0_sel = s0; m0_wdata = d0;
    m1_ce = c1; m1_we = w1; m1_addr = a1; m1_sel = s1; m1_wdata = d1;
    e = '{own: 1'b0, w0: 1'b0, w1: 1'b0, ce: 1'b0, we: 1'b0, chk0: 1'b0, chk1: 1'b0,
          addr: '0, wdata: '0, rd: '0, sel: '0};
    if (!r) begin
      e.chk0 = 1'b1;
      e.chk1 = 1'b1;
      m_own = 1'b0;
      m_served = 0;
      last_w0 = 1'b0;
      last_w1 = 1'b0;
    end else begin
      oce   = m_own ? c1 : c0;
      owe   = m_own ? w1 : w0;
      oa    = m_own ? a1 : a0;
      os    = m_own ? s1 : s0;
      od    = m_own ? d1 : d0;
      other = m_own ? c0 : c1;
      e.own = m_own;
      e.w0 = c0 && m_own;
      e.w1 = c1 && !m_own;
      e.ce = oce;
      e.we = oce && owe;
      e.addr = oa;
      e.sel = os;
      e.wdata = od;
      if (oce && !owe) begin
        e.rd = m_mem[oa[5:2]];
        if (m_own) e.chk1 = 1'b1;
        else e.chk0 = 1'b1;
      end
      last_w0 = e.w0;
      last_w1 = e.w1;
      // Master 1 releases as soon as it stops asking; otherwise a waiting master wins
      // when the owner is idle or has already used MaxBurst-1 slots of its tenure.
      sw = (m_own && !c1) || (other && (!oce || m_served >= MaxBurst - 1));
      if (e.we) begin
        for (int b = 0; b < 4; b++) if (os[b]) m_mem[oa[5:2]][8*b +: 8] = od[8*b +: 8];
      end
      if (oce) m_served++;
      if (sw) begin
        m_own = !m_own;
        m_served = 0;
      end
    end
    sb.push_back(e);
  endtask

  int run0 = 0, run1 = 0;

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("owner", owner, e.own);
      check("m0_wait", m0_wait, e.w0);
      check("m1_wait", m1_wait, e.w1);
      check("ram_ce", ram_ce, e.ce);
      check("ram_we", ram_we, e.we);
      if (e.ce) begin
        check("ram_addr", ram_addr, e.addr);
        check("ram_sel", ram_sel, e.sel);
        check("ram_wdata", ram_wdata, e.wdata);
      end
      if (e.chk0) check("m0_rdata", m0_rdata, e.rd);
      if (e.chk1) check("m1_rdata", m1_rdata, e.rd);
      if (m0_wait) run0++;
      else begin
        if (run0 > 0) check("m0_wait_run_bounded", 32'(run0 > MaxBurst), 32'd0);
        run0 = 0;
      end
      if (m1_wait) run1++;
      else begin
        if (run1 > 0) check("m1_wait_run_bounded", 32'(run1 > MaxBurst), 32'd0);
        run1 = 0;
      end
    end
  end

  logic        r_n, c0_n, w0_n, c1_n, w1_n;
  logic [31:0] a0_n, d0_n, a1_n, d1_n;
  logic [3:0]  s0_n, s1_n;

  initial begin
    // Reset held with both masters requesting, then contention from the park state.
    repeat (2) drive(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    repeat (8) drive(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    // CPU-only write then read-back.
    drive(1'b1, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    // Master 1 alone: one wait cycle, one served read, then release back to park.
    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    // Byte write via master 1 while master 0 waits with its own write pending.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h40, 4'b0010, 32'h0000AB00);
    drive(1'b1, 1'b1, 1'b1, 32'h44, 4'hF, 32'h11223344,
          1'b1, 1'b1, 32'h40, 4'b0010, 32'h0000AB00);
    repeat (2) drive(1'b1, 1'b1, 1'b1, 32'h44, 4'hF, 32'h11223344,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    // Reset in the middle of a master 1 burst, with a write presented during reset.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Random traffic; a waiting master holds its request unchanged.
    for (int i = 0; i < 600; i++) begin
      r_n = ($urandom_range(0, 39) != 0);
      if (last_w0) begin
        c0_n = m0_ce; w0_n = m0_we; a0_n = m0_addr; s0_n = m0_sel; d0_n = m0_wdata;
      end else begin
        c0_n = ($urandom_range(0, 3) != 0);
        w0_n = $urandom_range(0, 1) == 1;
        a0_n = 32'($urandom_range(0, 15)) << 2;
        s0_n = 4'($urandom_range(1, 15));
        d0_n = $urandom;
      end
      if (last_w1) begin
        c1_n = m1_ce; w1_n = m1_we; a1_n = m1_addr; s1_n = m1_sel; d1_n = m1_wdata;
      end else begin
        c1_n = ($urandom_range(0, 1) == 1);
        w1_n = $urandom_range(0, 1) == 1;
        a1_n = 32'($urandom_range(0, 15)) << 2;
        s1_n = 4'($urandom_range(1, 15));
        d1_n = $urandom;
      end
      drive(r_n, c0_n, w0_n, a0_n, s0_n, d0_n, c1_n, w1_n, a1_n, s1_n, d1_n);
    end

    // Read back every word through master 0 to catch any stray write.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i) << 2, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      while (last_w0) begin
        drive(1'b1, 1'b1, 1'b0, 32'(i) << 2, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
